// File: rtl/mux_arbiter_pkg.sv
// Shared sizes and FSM state type for the round-robin mux arbiter.
// Holds no logic, so it has no latency and applies no backpressure.
package mux_arb_pkg;
   localparam int NREQ  = 5;
   localparam int SEL_W = 4;
   localparam int SRC_W = 3;

   typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Round-robin search: first set req bit at or after start, wrapping N-1 -> 0.
// Purely combinational (zero latency); has no flow control of its own.
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N = NREQ
) (
   input  logic [N-1:0]     req,
   input  logic [SRC_W-1:0] start,
   output logic             any,
   output logic [SRC_W-1:0] idx
);

   function automatic int wrap_idx(input int v);
      return (v >= N) ? v - N : v;
   endfunction

   // Walk from the far end so the candidate closest to start is written last and wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[SRC_W'(wrap_idx(int'(start) + i))]) begin
            any = 1'b1;
            idx = SRC_W'(wrap_idx(int'(start) + i));
         end
      end
   end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner of a shared 5:1 mux; grant one edge after req, capture the edge after.
// Holder keeps the mux up to MAX_HOLD captures while others wait; MUX_ARB_LOCK_EN adds lock to suspend that limit.
module mux_arbiter #(
   parameter int WIDTH    = 32,
   parameter int NREQ     = mux_arb_pkg::NREQ,
   parameter int MAX_HOLD = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NREQ-1:0]                req,
`ifdef MUX_ARB_LOCK_EN
   input  logic                           lock,
`endif
   input  logic [WIDTH-1:0]               mux_o,
   output logic [mux_arb_pkg::SEL_W-1:0]  sel,
   output logic [NREQ-1:0]                gnt,
   output logic [WIDTH-1:0]               data_out,
   output logic                           data_valid,
   output logic [mux_arb_pkg::SRC_W-1:0]  data_src
);
   import mux_arb_pkg::*;

   state_t           state, state_nxt;
   logic [NREQ-1:0]  gnt_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic [WIDTH-1:0] data_out_nxt;
   logic             data_valid_nxt;
   logic [SRC_W-1:0] data_src_nxt;
   logic [3:0]       hold_cnt, hold_cnt_nxt;
   logic [SRC_W-1:0] last_winner, last_winner_nxt;
   logic [SRC_W-1:0] start, pick;
   logic             pick_vld, cap, others, hold_hit, lock_act, rotate;

`ifdef MUX_ARB_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   // While granted, last_winner is the current owner, so one search serves both IDLE and rotation.
   assign start    = (last_winner == SRC_W'(NREQ - 1)) ? '0 : last_winner + 1'b1;
   assign cap      = req[last_winner];
   assign others   = |(req & ~(NREQ'(1) << last_winner));
   assign hold_hit = ({1'b0, hold_cnt} + 5'd1) >= 5'(MAX_HOLD);

   rr_pick #(.N(NREQ)) u_pick (
      .req   (req),
      .start (start),
      .any   (pick_vld),
      .idx   (pick)
   );

   always_comb begin
      state_nxt       = state;
      gnt_nxt         = gnt;
      sel_nxt         = sel;
      data_out_nxt    = data_out;
      data_valid_nxt  = 1'b0;
      data_src_nxt    = data_src;
      hold_cnt_nxt    = hold_cnt;
      last_winner_nxt = last_winner;
      rotate          = 1'b0;

      case (state)
         IDLE: begin
            if (pick_vld) rotate = 1'b1;
         end
         GRANT: begin
            if (cap) begin
               data_out_nxt   = mux_o;
               data_src_nxt   = last_winner;
               data_valid_nxt = 1'b1;
               if (hold_hit && others && !lock_act)
                  rotate = 1'b1;
               else if (hold_cnt < 4'(MAX_HOLD))
                  hold_cnt_nxt = hold_cnt + 4'd1;
            end else if (pick_vld) begin
               rotate = 1'b1;
            end else begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (rotate) begin
         state_nxt       = GRANT;
         gnt_nxt         = '0;
         gnt_nxt[pick]   = 1'b1;
         sel_nxt         = SEL_W'(pick);
         last_winner_nxt = pick;
         hold_cnt_nxt    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gnt         <= '0;
         sel         <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         data_src    <= '0;
         hold_cnt    <= '0;
         last_winner <= SRC_W'(NREQ - 1);
      end else begin
         state       <= state_nxt;
         gnt         <= gnt_nxt;
         sel         <= sel_nxt;
         data_out    <= data_out_nxt;
         data_valid  <= data_valid_nxt;
         data_src    <= data_src_nxt;
         hold_cnt    <= hold_cnt_nxt;
         last_winner <= last_winner_nxt;
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: expected captures are queued as stimulus is applied and
// popped by a negedge monitor; the lock scenario is built only when MUX_ARB_LOCK_EN is defined.
module tb_mux_arbiter;

   typedef struct packed {
      logic [31:0] dat;
      logic [2:0]  src;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  req   = '0;
   logic [31:0] mux_o;
   logic [3:0]  sel;
   logic [4:0]  gnt;
   logic [31:0] data_out;
   logic        data_valid;
   logic [2:0]  data_src;
`ifdef MUX_ARB_LOCK_EN
   logic        lock  = 1'b0;
`endif

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   assign mux_o = 32'd1 << sel;

   mux_arbiter #(.WIDTH(32), .NREQ(5), .MAX_HOLD(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
`ifdef MUX_ARB_LOCK_EN
      .lock       (lock),
`endif
      .mux_o      (mux_o),
      .sel        (sel),
      .gnt        (gnt),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_src   (data_src)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int src, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.dat = 32'd1 << src;
         e.src = 3'(src);
         sb.push_back(e);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req   = '0;
      next();
      next();
      rst_n = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, 32'(gnt), 32'd0);
      check({tag, "_sel"}, 32'(sel), 32'd0);
      check({tag, "_data_out"}, data_out, 32'd0);
      check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
      check({tag, "_data_src"}, 32'(data_src), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && data_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_capture", 32'(data_valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("cap_data", data_out, mon_e.dat);
            check("cap_src", 32'(data_src), 32'(mon_e.src));
         end
      end
   end

   initial begin
      // Reset state, first grant/capture latency, then a mid-cycle reset abort.
      next();
      check_zero("reset");
      rst_n = 1'b1;
      req   = 5'b00001;
      push(0, 1);
      next();
      check("first_gnt", 32'(gnt), 32'h01);
      check("first_sel", 32'(sel), 32'd0);
      check("first_no_cap", 32'(data_valid), 32'd0);
      next();
      check("first_cap_vld", 32'(data_valid), 32'd1);
      check("first_cap_dat", data_out, 32'd1);
      #4;
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      req = '0;
      next();
      next();
      rst_n = 1'b1;
      check("sb_empty_reset", 32'(sb.size()), 32'd0);

      // Single requester held: grant never drops after hold saturates.
      req = 5'b00100;
      push(2, 10);
      next();
      check("hold_gnt_e1", 32'(gnt), 32'h04);
      check("hold_sel_e1", 32'(sel), 32'd2);
      for (int i = 0; i < 10; i++) begin
         next();
         check("hold_gnt", 32'(gnt), 32'h04);
         check("hold_vld", 32'(data_valid), 32'd1);
      end
      req = '0;
      next();
      check("hold_release_gnt", 32'(gnt), 32'd0);
      check("hold_release_sel", 32'(sel), 32'd2);
      check("hold_release_vld", 32'(data_valid), 32'd0);
      next();
      check("sb_empty_hold", 32'(sb.size()), 32'd0);

      // All requesting: four captures each in round-robin order, no gaps.
      apply_reset();
      req = 5'b11111;
      for (int s = 0; s < 5; s++) push(s, 4);
      push(0, 4);
      next();
      check("fair_gnt_e1", 32'(gnt), 32'h01);
      for (int i = 0; i < 24; i++) begin
         next();
         check("fair_vld", 32'(data_valid), 32'd1);
         check("fair_gnt_sel", 32'(gnt), 32'(5'b00001 << sel));
      end
      req = '0;
      next();
      check("fair_idle_gnt", 32'(gnt), 32'd0);
      next();
      check("sb_empty_fair", 32'(sb.size()), 32'd0);

      // Owner 4 drops while source 1 asks: wrap-around rotation on the same edge.
      req = 5'b10000;
      push(4, 1);
      next();
      check("wrap_gnt4", 32'(gnt), 32'h10);
      check("wrap_sel4", 32'(sel), 32'd4);
      next();
      req = 5'b00010;
      push(1, 2);
      next();
      check("wrap_gnt1", 32'(gnt), 32'h02);
      check("wrap_sel1", 32'(sel), 32'd1);
      check("wrap_no_cap", 32'(data_valid), 32'd0);
      next();
      next();
      req = '0;
      next();
      check("wrap_idle_gnt", 32'(gnt), 32'd0);
      next();
      check("sb_empty_wrap", 32'(sb.size()), 32'd0);

`ifdef MUX_ARB_LOCK_EN
      // Lock holds source 0 past MAX_HOLD; releasing lock rotates at the next capture.
      apply_reset();
      req  = 5'b00011;
      lock = 1'b1;
      push(0, 13);
      push(1, 2);
      next();
      for (int i = 0; i < 12; i++) begin
         next();
         check("lock_gnt0", 32'(gnt), 32'h01);
      end
      lock = 1'b0;
      next();
      check("unlock_gnt1", 32'(gnt), 32'h02);
      next();
      next();
      req = '0;
      next();
      next();
      check("sb_empty_lock", 32'(sb.size()), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
